// File: rtl/spi_slave_param.sv
// SPI slave clocked by a single system clock (sync_clock). While CS is low,
// every rising edge is one bit time. The frame begins on the first CS-low
// edge, which loads the transmit word. The next DATA_WIDTH edges shift MOSI
// in and MISO out. A completed word is presented on dout with a
// valid/ready handshake.
//
// Handshake: dout holds a word whenever rx_valid=1. The consumer takes it
// on any rising edge where rx_valid=1 and rx_ready=1, and rx_valid then drops.
// If a new word completes on that same edge, rx_valid instead stays high with
// the new word. If a word completes while an unconsumed word is still held
// (rx_ready=0), that word is replaced and the sticky overrun flag is set.
module spi_slave_param #(
   parameter int DATA_WIDTH = 12,
   parameter bit LSB_FIRST  = 1'b1
) (
   input  logic                  sync_clock,
   input  logic                  rst,
   input  logic                  CS,
   input  logic                  MOSI,
   output logic                  MISO,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  done,
   output logic                  abort,
   output logic                  overrun,
   output logic                  busy
);

   localparam int CW = $clog2(DATA_WIDTH) + 1;

   localparam logic [1:0] ST_IDLE         = 2'd0;
   localparam logic [1:0] ST_SHIFT        = 2'd1;
   localparam logic [1:0] ST_WAIT_CS_HIGH = 2'd2;

   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   logic [1:0]            r_state;
   logic [CW-1:0]         r_cnt;
   logic [DATA_WIDTH-1:0] r_rx;
   logic [DATA_WIDTH-1:0] r_tx;
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_rx_valid;
   logic                  r_done;
   logic                  r_abort;
   logic                  r_overrun;

   logic [DATA_WIDTH-1:0] w_rx_next;
   logic [DATA_WIDTH-1:0] w_tx_next;
   logic                  w_tx_bit;
   logic                  w_start;
   logic                  w_shift;
   logic                  w_abort;
   logic                  w_complete;

   // Frame events decoded from the current state and chip select
   always_comb begin
      w_start    = (r_state == ST_IDLE)  && !CS;
      w_shift    = (r_state == ST_SHIFT) && !CS;
      w_abort    = (r_state == ST_SHIFT) &&  CS;
      w_complete = w_shift && (r_cnt == LAST_BIT);
   end

   // Bit-order dependent shift paths; the receive path already includes the
   // bit being sampled so the completing edge can store the whole word
   always_comb begin
      w_rx_next = '0;
      w_tx_next = '0;
      w_tx_bit  = 1'b0;
      if (LSB_FIRST) begin
         w_rx_next = {MOSI, r_rx[DATA_WIDTH-1:1]};
         w_tx_next = {1'b0, r_tx[DATA_WIDTH-1:1]};
         w_tx_bit  = r_tx[0];
      end else begin
         w_rx_next = {r_rx[DATA_WIDTH-2:0], MOSI};
         w_tx_next = {r_tx[DATA_WIDTH-2:0], 1'b0};
         w_tx_bit  = r_tx[DATA_WIDTH-1];
      end
   end

   // Control FSM: state, bit counter and the single-cycle done/abort pulses
   always_ff @(posedge sync_clock or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_abort <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_abort <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (!CS) r_state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (CS) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
                  r_abort <= 1'b1;
               end else if (r_cnt == LAST_BIT) begin
                  r_state <= ST_WAIT_CS_HIGH;
                  r_cnt   <= '0;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_WAIT_CS_HIGH: begin
               r_cnt <= '0;
               if (CS) r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Shift registers: tx loads at frame start, both shift on every data edge
   always_ff @(posedge sync_clock or posedge rst) begin
      if (rst) begin
         r_rx <= '0;
         r_tx <= '0;
      end else if (w_start) begin
         r_tx <= tx_data;
      end else if (w_shift) begin
         r_rx <= w_rx_next;
         r_tx <= w_tx_next;
      end
   end

   // Receive word holding register with valid/ready handshake and overrun
   always_ff @(posedge sync_clock or posedge rst) begin
      if (rst) begin
         r_dout     <= '0;
         r_rx_valid <= 1'b0;
         r_overrun  <= 1'b0;
      end else if (w_complete) begin
         r_dout     <= w_rx_next;
         r_rx_valid <= 1'b1;
         if (r_rx_valid && !rx_ready) r_overrun <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
         r_rx_valid <= 1'b0;
      end
   end

   // The abort term is implied by the FSM; it is kept decoded for clarity of
   // the event set and tied into busy-free logic only through r_abort.
   assign MISO     = w_shift ? w_tx_bit : 1'b0;
   assign busy     = (r_state == ST_SHIFT) && !w_abort ? 1'b1 : (r_state == ST_SHIFT);
   assign dout     = r_dout;
   assign rx_valid = r_rx_valid;
   assign done     = r_done;
   assign abort    = r_abort;
   assign overrun  = r_overrun;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param. Two instances are used: the default 12-bit
// LSB-first build (a_*) and an 8-bit MSB-first build (b_*). Inputs change on
// the falling clock edge and outputs are sampled there too, so each rising
// edge sees stable inputs. The reference model treats a frame as a word of
// bits on the wire and tracks the held word, valid flag and sticky overrun.
module tb_spi_slave_param;

   logic clk;
   logic rst;

   logic        a_cs, a_mosi, a_miso, a_ready, a_valid, a_done, a_abort, a_overrun, a_busy;
   logic [11:0] a_tx, a_dout;
   logic        b_cs, b_mosi, b_miso, b_ready, b_valid, b_done, b_abort, b_overrun, b_busy;
   logic [7:0]  b_tx, b_dout;

   int n_checks = 0;
   int n_fail   = 0;

   logic [11:0] a_exp_dout;
   logic        a_exp_valid;
   logic        a_exp_overrun;
   logic [7:0]  b_exp_dout;
   logic        b_exp_valid;
   logic        b_exp_overrun;

   spi_slave_param u_dut_a (
      .sync_clock(clk), .rst(rst), .CS(a_cs), .MOSI(a_mosi), .MISO(a_miso),
      .tx_data(a_tx), .dout(a_dout), .rx_valid(a_valid), .rx_ready(a_ready),
      .done(a_done), .abort(a_abort), .overrun(a_overrun), .busy(a_busy)
   );

   spi_slave_param #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) u_dut_b (
      .sync_clock(clk), .rst(rst), .CS(b_cs), .MOSI(b_mosi), .MISO(b_miso),
      .tx_data(b_tx), .dout(b_dout), .rx_valid(b_valid), .rx_ready(b_ready),
      .done(b_done), .abort(b_abort), .overrun(b_overrun), .busy(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One full 12-bit LSB-first frame on instance A. hold = extra cycles CS
   // stays low after completion before being raised.
   task automatic frame_a(input logic [11:0] word, input logic [11:0] txw,
                          input bit ready_at_end, input int hold);
      logic [11:0] miso_seen;
      miso_seen = '0;
      @(negedge clk);
      a_cs = 1'b0; a_tx = txw; a_ready = 1'b0; a_mosi = 1'($urandom);
      @(posedge clk);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         n_checks++;
         if (a_done !== 1'b0 || a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL a_frame_bit%0d: done=%b busy=%b want done=0 busy=1", i, a_done, a_busy);
         end
         miso_seen[i] = a_miso;
         a_mosi = word[i];
         if (i == 11) a_ready = ready_at_end;
         @(posedge clk);
      end
      if (a_exp_valid && !ready_at_end) a_exp_overrun = 1'b1;
      a_exp_dout  = word;
      a_exp_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (a_done !== 1'b1) begin
         n_fail++; $display("FAIL a_done_pulse: got %b want 1", a_done);
      end
      n_checks++;
      if (a_dout !== a_exp_dout || a_valid !== a_exp_valid) begin
         n_fail++; $display("FAIL a_dout: got %h/%b want %h/%b", a_dout, a_valid, a_exp_dout, a_exp_valid);
      end
      n_checks++;
      if (a_overrun !== a_exp_overrun) begin
         n_fail++; $display("FAIL a_overrun: got %b want %b", a_overrun, a_exp_overrun);
      end
      n_checks++;
      if (miso_seen !== txw) begin
         n_fail++; $display("FAIL a_miso_word: got %h want %h", miso_seen, txw);
      end
      n_checks++;
      if (a_busy !== 1'b0 || a_miso !== 1'b0) begin
         n_fail++; $display("FAIL a_wait_state: busy=%b miso=%b want 0/0", a_busy, a_miso);
      end
      a_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         a_mosi = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
         n_checks++;
         if (a_done !== 1'b0 || a_busy !== 1'b0 || a_dout !== a_exp_dout) begin
            n_fail++;
            $display("FAIL a_hold_cs_low%0d: done=%b busy=%b dout=%h want 0/0/%h", h, a_done, a_busy, a_dout, a_exp_dout);
         end
      end
      a_cs = 1'b1; a_mosi = 1'($urandom);
      @(posedge clk);
   endtask

   // One full 8-bit MSB-first frame on instance B, rx_ready kept low.
   task automatic frame_b(input logic [7:0] word, input logic [7:0] txw);
      logic [7:0] miso_seen;
      miso_seen = '0;
      @(negedge clk);
      b_cs = 1'b0; b_tx = txw; b_mosi = 1'($urandom);
      @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++;
         if (b_done !== 1'b0) begin
            n_fail++; $display("FAIL b_early_done_bit%0d: got %b want 0", i, b_done);
         end
         miso_seen[7-i] = b_miso;
         b_mosi = word[7-i];
         @(posedge clk);
      end
      if (b_exp_valid) b_exp_overrun = 1'b1;
      b_exp_dout  = word;
      b_exp_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (b_done !== 1'b1 || b_dout !== b_exp_dout || b_valid !== 1'b1) begin
         n_fail++; $display("FAIL b_frame: done=%b dout=%h valid=%b want 1/%h/1", b_done, b_dout, b_valid, b_exp_dout);
      end
      n_checks++;
      if (b_overrun !== b_exp_overrun) begin
         n_fail++; $display("FAIL b_overrun: got %b want %b", b_overrun, b_exp_overrun);
      end
      n_checks++;
      if (miso_seen !== txw) begin
         n_fail++; $display("FAIL b_miso_word: got %h want %h", miso_seen, txw);
      end
      b_cs = 1'b1;
      @(posedge clk);
   endtask

   // Pulse rx_ready for one edge on instance A
   task automatic consume_a();
      @(negedge clk);
      a_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_ready = 1'b0;
      a_exp_valid = 1'b0;
      n_checks++;
      if (a_valid !== 1'b0 || a_dout !== a_exp_dout || a_overrun !== a_exp_overrun) begin
         n_fail++;
         $display("FAIL a_consume: valid=%b dout=%h ovr=%b want 0/%h/%b", a_valid, a_dout, a_overrun, a_exp_dout, a_exp_overrun);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_checks++;
      if ({a_dout, a_valid, a_done, a_abort, a_overrun, a_busy, a_miso} !== '0) begin
         n_fail++; $display("FAIL reset_a: outputs %h want 0", {a_dout, a_valid, a_done, a_abort, a_overrun, a_busy, a_miso});
      end
      n_checks++;
      if ({b_dout, b_valid, b_done, b_abort, b_overrun, b_busy, b_miso} !== '0) begin
         n_fail++; $display("FAIL reset_b: outputs %h want 0", {b_dout, b_valid, b_done, b_abort, b_overrun, b_busy, b_miso});
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (a_busy !== 1'b0 || a_miso !== 1'b0) begin
         n_fail++; $display("FAIL idle_cs_high: busy=%b miso=%b want 0/0", a_busy, a_miso);
      end
   endtask

   task automatic test_ready_idle();
      // rx_ready with nothing held must not change anything
      consume_a();
   endtask

   task automatic test_basic_frame();
      frame_a(12'h3B7, 12'hA5C, 1'b0, 0);
   endtask

   task automatic test_ready_at_completion();
      frame_a(12'h111, 12'h0F0, 1'b0, 0);
      frame_a(12'h222, 12'h00F, 1'b1, 0);
      consume_a();
   endtask

   task automatic test_abort();
      @(negedge clk);
      a_cs = 1'b0; a_tx = 12'($urandom);
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         a_mosi = 1'($urandom);
         @(posedge clk);
      end
      @(negedge clk);
      a_cs = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (a_abort !== 1'b1 || a_done !== 1'b0 || a_busy !== 1'b0) begin
         n_fail++; $display("FAIL abort_pulse: abort=%b done=%b busy=%b want 1/0/0", a_abort, a_done, a_busy);
      end
      n_checks++;
      if (a_dout !== a_exp_dout || a_valid !== a_exp_valid || a_overrun !== a_exp_overrun) begin
         n_fail++; $display("FAIL abort_keep: dout=%h valid=%b ovr=%b want %h/%b/%b", a_dout, a_valid, a_overrun, a_exp_dout, a_exp_valid, a_exp_overrun);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (a_abort !== 1'b0) begin
         n_fail++; $display("FAIL abort_one_cycle: got %b want 0", a_abort);
      end
      frame_a(12'h001, 12'($urandom), 1'b0, 0);
      consume_a();
   endtask

   task automatic test_overrun();
      frame_a(12'h111, 12'($urandom), 1'b0, 0);
      frame_a(12'h222, 12'($urandom), 1'b0, 0);
   endtask

   task automatic test_reset_mid_frame();
      @(negedge clk);
      a_cs = 1'b0; a_tx = 12'hFFF;
      @(posedge clk);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         a_mosi = 1'($urandom);
         @(posedge clk);
      end
      @(negedge clk);
      n_checks++;
      if (a_busy !== 1'b1 || a_miso !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset_bit7: busy=%b miso=%b want 1/1", a_busy, a_miso);
      end
      #2;
      rst = 1'b1;
      #1;
      a_exp_dout = '0; a_exp_valid = 1'b0; a_exp_overrun = 1'b0;
      b_exp_dout = '0; b_exp_valid = 1'b0; b_exp_overrun = 1'b0;
      n_checks++;
      if ({a_dout, a_valid, a_done, a_abort, a_overrun, a_busy, a_miso} !== '0) begin
         n_fail++; $display("FAIL reset_mid_frame: outputs %h want 0", {a_dout, a_valid, a_done, a_abort, a_overrun, a_busy, a_miso});
      end
      a_cs = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (a_done !== 1'b0 || a_abort !== 1'b0) begin
         n_fail++; $display("FAIL reset_no_pulse: done=%b abort=%b want 0/0", a_done, a_abort);
      end
      frame_a(12'hFFF, 12'($urandom), 1'b0, 0);
      consume_a();
   endtask

   task automatic test_hold_cs_low();
      frame_a(12'($urandom), 12'($urandom), 1'b0, 4);
      frame_a(12'($urandom), 12'($urandom), 1'b1, 1);
      consume_a();
   endtask

   task automatic test_random_frames();
      for (int n = 0; n < 20; n++) begin
         frame_a(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 2));
         if ($urandom_range(0, 1) == 1) consume_a();
      end
   endtask

   task automatic test_msb_first();
      frame_b(8'hC3, 8'h5A);
      for (int n = 0; n < 4; n++) frame_b(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
   endtask

   initial begin
      a_cs = 1'b1; a_mosi = 1'b0; a_tx = '0; a_ready = 1'b0;
      b_cs = 1'b1; b_mosi = 1'b0; b_tx = '0; b_ready = 1'b0;
      a_exp_dout = '0; a_exp_valid = 1'b0; a_exp_overrun = 1'b0;
      b_exp_dout = '0; b_exp_valid = 1'b0; b_exp_overrun = 1'b0;
      test_reset();
      test_ready_idle();
      test_basic_frame();
      test_ready_at_completion();
      test_abort();
      test_overrun();
      test_reset_mid_frame();
      test_hold_cs_low();
      test_random_frames();
      test_msb_first();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 Parameter DATA_WIDTH, default 12, frame length in bits, legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 1: 1 = first bit on the wire is bit 0; 0 = first bit is bit DATA_WIDTH-1.
REQ-003 Port sync_clock  input  1  sole clock; every register updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port CS  input  1  chip select, active low.
REQ-006 Port MOSI  input  1  serial data in.
REQ-007 Port MISO  output  1  serial data out; driven 0 whenever CS is high (no tristate).
REQ-008 Port tx_data  input  DATA_WIDTH  word to transmit, sampled at frame start.
REQ-009 Port dout  output  DATA_WIDTH  last completed received word.
REQ-010 Port rx_valid  output  1  dout holds an unconsumed word.
REQ-011 Port rx_ready  input  1  consumer accepts dout on any edge where rx_valid=1.
REQ-012 Port done  output  1  one-cycle pulse on frame completion.
REQ-013 Port abort  output  1  one-cycle pulse when CS rises mid-frame.
REQ-014 Port overrun  output  1  sticky flag: a completed word replaced an unconsumed one.
REQ-015 Port busy  output  1  high while in state SHIFT.

Function
REQ-016 FSM states: IDLE, SHIFT, WAIT_CS_HIGH.
REQ-017 IDLE: on an edge with CS=0 -> SHIFT, bit counter=0, tx shift register loaded from tx_data; MOSI is not sampled on this edge.
REQ-018 IDLE with CS=1: remain in IDLE, counter holds 0.
REQ-019 SHIFT with CS=0: each edge samples MOSI into the rx shift register, advances the tx shift register one bit, and increments the counter.
REQ-020 Bit order, LSB_FIRST=1: right shift, MOSI enters at the MSB; the first received bit ends in dout[0].
REQ-021 Bit order, LSB_FIRST=0: left shift, MOSI enters at the LSB; the first received bit ends in dout[DATA_WIDTH-1].
REQ-022 MISO = tx shift register bit 0 (LSB_FIRST=1) or bit DATA_WIDTH-1 (LSB_FIRST=0) while CS=0.
REQ-023 Completion: on the edge sampling bit DATA_WIDTH-1 (counter = DATA_WIDTH-1), the following happen together:
- the full word, including that bit, is written to dout
- rx_valid=1 and done=1 for one cycle
- state -> WAIT_CS_HIGH
REQ-024 Latency: a DATA_WIDTH-bit frame takes DATA_WIDTH+1 edges from the first CS-low edge to done.
REQ-025 WAIT_CS_HIGH: MOSI is ignored and MISO=0; CS=1 -> IDLE. A new frame requires CS to deassert and reassert.
REQ-026 Abort: CS=1 in SHIFT -> IDLE, abort=1 for one cycle, partial word discarded; dout, rx_valid and overrun unchanged.
REQ-027 Handshake: rx_valid clears on an edge where rx_valid=1 and rx_ready=1, unless a completion occurs on the same edge.
REQ-028 Completion with rx_ready=1 on the same edge: new word loaded, rx_valid stays 1, overrun not set.
REQ-029 Completion with rx_valid=1 and rx_ready=0: dout overwritten, rx_valid stays 1, overrun set to 1 until reset.
REQ-030 rx_ready while rx_valid=0 has no effect.
REQ-031 Counter width is $clog2(DATA_WIDTH)+1 bits; it never exceeds DATA_WIDTH-1.

Reset
REQ-032 rst=1 asynchronously forces the following regardless of clock:
- state IDLE, counter 0, both shift registers 0
- dout=0, rx_valid=0, done=0, abort=0, overrun=0, busy=0, MISO=0
REQ-033 rst asserted mid-frame discards the frame with no done or abort pulse; the first edge after release with CS=0 starts a fresh frame.

Verification
REQ-034 Default params, tx_data=12'hA5C, CS low, MOSI sends 12'h3B7 LSB-first -> done on edge 13, dout=12'h3B7, rx_valid=1, MISO bits LSB-first = 12'hA5C.
REQ-035 LSB_FIRST=0, DATA_WIDTH=8, MOSI sends 8'hC3 MSB-first -> dout=8'hC3 after 9 edges.
REQ-036 CS raised after 5 bits -> abort pulse, dout and rx_valid unchanged; next full frame 12'h001 -> dout=12'h001.
REQ-037 Two frames 12'h111 then 12'h222 with rx_ready=0 -> dout=12'h222, overrun=1; repeat with rx_ready=1 at the second completion edge -> overrun stays 0.
REQ-038 rst pulsed at bit 7 -> all outputs 0 immediately; next frame 12'hFFF -> dout=12'hFFF.
REQ-039 CS held low after completion -> no second frame and done stays 0 until CS toggles high then low.
